digit_stream_out: RTL and testbench

Readout counterpart of the calculator's digit-entry shift register. On a load request it captures a packed hex value of `NDIGITS` 4-bit digits. It then streams those digits most-significant first as 8-bit ASCII characters over a valid/ready handshake. The display text path uses it to paint the calculator visor one character at a time.

---
 rtl/digit_stream_out.sv | 233 +++++++++++++++++++++++
 tb/tb_digit_stream_out.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/digit_stream_out.sv
// -----------------------------------------------------------------------------
// digit_stream_out
//
// Readout side of the calculator digit path. A load request in IDLE captures
// NDIGITS packed 4-bit digits into a shadow register. The block then offers
// them most-significant first as ASCII characters on a valid/ready handshake.
// A one-cycle done pulse follows the final transfer.
//
// Parameters
//   NDIGITS    number of 4-bit digits in value (1..16)
//   UPPER_HEX  0: digits 10..15 -> 'a'..'f', 1: 'A'..'F'
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high reset
//   load        in   start request, honoured only in IDLE
//   value       in   packed digits, digit i = value[4i+3:4i]
//   busy        out  high in SEND and DONE
//   char_valid  out  character offered
//   char_ready  in   sink accepts (transfer = char_valid & char_ready)
//   char_data   out  ASCII character (0 when char_valid is low)
//   char_index  out  digit position offered (0 when char_valid is low)
//   char_last   out  final character (index 0)
//   done        out  one-cycle pulse after the final transfer
//
// Optional feature
//   DIGIT_STREAM_LZ_BLANK_EN  when defined, leading zero digits (index > 0)
//                             are sent as spaces. Index 0 is always a numeral.
//
// All outputs are registered. Their next values are derived from the next
// state, so an output and the state it describes change on the same edge.
// -----------------------------------------------------------------------------
module digit_stream_out #(
  parameter int NDIGITS   = 10,
  parameter bit UPPER_HEX = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  output logic                   busy,
  output logic                   char_valid,
  input  logic                   char_ready,
  output logic [7:0]             char_data,
  output logic [3:0]             char_index,
  output logic                   char_last,
  output logic                   done
);

  localparam int VW = 4 * NDIGITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(NDIGITS - 1);

  // Select digit idx from a packed value. Index values outside 0..NDIGITS-1
  // cannot occur; they return 0.
  function automatic logic [3:0] digit_at(input logic [VW-1:0] v,
                                          input logic [3:0]    idx);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == 4'(i)) begin
        d = v[4*i +: 4];
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

  // Hex digit to ASCII numeral, letter case selected by UPPER_HEX.
  function automatic logic [7:0] hex_ascii(input logic [3:0] d);
    logic [7:0] c;
    if (d < 4'd10) begin
      c = 8'h30 + {4'h0, d};
    end else begin
      c = (UPPER_HEX ? 8'h41 : 8'h61) + {4'h0, d - 4'd10};
    end
    return c;
  endfunction

`ifdef DIGIT_STREAM_LZ_BLANK_EN
  // Character for a digit with leading-zero blanking. A zero is blanked only
  // while no nonzero digit has been sent and it is not the last position.
  function automatic logic [7:0] glyph(input logic [3:0] d,
                                       input logic [3:0] idx,
                                       input logic       nz_seen);
    logic [7:0] c;
    if (!nz_seen && (d == 4'd0) && (idx != 4'd0)) begin
      c = 8'h20;
    end else begin
      c = hex_ascii(d);
    end
    return c;
  endfunction
`endif

  // State and datapath registers
  logic [1:0]    state_q,  state_d;
  logic [VW-1:0] shadow_q, shadow_d;
  logic [3:0]    index_q,  index_d;
`ifdef DIGIT_STREAM_LZ_BLANK_EN
  // Set once a nonzero digit has been transferred in the current stream;
  // cleared at capture. While clear, the stream is still in its zero run.
  logic          nz_seen_q, nz_seen_d;
`endif

  // Registered outputs
  logic          busy_q,       busy_d;
  logic          char_valid_q, char_valid_d;
  logic [7:0]    char_data_q,  char_data_d;
  logic [3:0]    char_index_q, char_index_d;
  logic          char_last_q,  char_last_d;
  logic          done_q,       done_d;

  logic          xfer_s;
  logic [3:0]    cur_digit_s;
  logic [3:0]    next_digit_s;

  // Next-state logic: capture, index stepping and end-of-stream detection.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    index_d     = index_q;
`ifdef DIGIT_STREAM_LZ_BLANK_EN
    nz_seen_d   = nz_seen_q;
`endif
    cur_digit_s = digit_at(shadow_q, index_q);
    xfer_s      = char_valid_q & char_ready;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shadow_d  = value;
          index_d   = LAST_IDX;
`ifdef DIGIT_STREAM_LZ_BLANK_EN
          nz_seen_d = 1'b0;
`endif
          state_d   = ST_SEND;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (xfer_s) begin
          if (index_q == 4'd0) begin
            state_d = ST_DONE;
          end else begin
            index_d   = index_q - 4'd1;
`ifdef DIGIT_STREAM_LZ_BLANK_EN
            nz_seen_d = nz_seen_q | (cur_digit_s != 4'd0);
`endif
            state_d   = ST_SEND;
          end
        end else begin
          // Stall: offer held unchanged.
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        // load is deliberately ignored here; it is not queued.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values, derived from the next state so they align with it.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    char_valid_d = (state_d == ST_SEND);
    done_d       = (state_d == ST_DONE);
    next_digit_s = digit_at(shadow_d, index_d);

    if (char_valid_d) begin
      char_index_d = index_d;
      char_last_d  = (index_d == 4'd0);
`ifdef DIGIT_STREAM_LZ_BLANK_EN
      char_data_d  = glyph(next_digit_s, index_d, nz_seen_d);
`else
      char_data_d  = hex_ascii(next_digit_s);
`endif
    end else begin
      char_index_d = 4'd0;
      char_last_d  = 1'b0;
      char_data_d  = 8'd0;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      index_q      <= 4'd0;
`ifdef DIGIT_STREAM_LZ_BLANK_EN
      nz_seen_q    <= 1'b0;
`endif
      busy_q       <= 1'b0;
      char_valid_q <= 1'b0;
      char_data_q  <= 8'd0;
      char_index_q <= 4'd0;
      char_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      index_q      <= index_d;
`ifdef DIGIT_STREAM_LZ_BLANK_EN
      nz_seen_q    <= nz_seen_d;
`endif
      busy_q       <= busy_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      char_index_q <= char_index_d;
      char_last_q  <= char_last_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign char_valid = char_valid_q;
  assign char_data  = char_data_q;
  assign char_index = char_index_q;
  assign char_last  = char_last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_digit_stream_out.sv
module tb_digit_stream_out;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        char_ready;
  logic        sel;          // 0: lower-case instance, 1: upper-case instance
  logic [39:0] value;

  logic       l_busy, l_valid, l_last, l_done;
  logic [7:0] l_data;
  logic [3:0] l_idx;
  logic       u_busy, u_valid, u_last, u_done;
  logic [7:0] u_data;
  logic [3:0] u_idx;

  logic       o_busy, o_valid, o_last, o_done;
  logic [7:0] o_data;
  logic [3:0] o_idx;

  int errors = 0;
  int checks = 0;

  string s_plain, s_zero, s_seq, s_upper;

  always #5 clk = ~clk;

  digit_stream_out #(.NDIGITS(10), .UPPER_HEX(1'b0)) dut_l (
    .clk(clk), .reset(reset), .load(load & ~sel), .value(value),
    .busy(l_busy), .char_valid(l_valid), .char_ready(char_ready & ~sel),
    .char_data(l_data), .char_index(l_idx), .char_last(l_last), .done(l_done)
  );

  digit_stream_out #(.NDIGITS(10), .UPPER_HEX(1'b1)) dut_u (
    .clk(clk), .reset(reset), .load(load & sel), .value(value),
    .busy(u_busy), .char_valid(u_valid), .char_ready(char_ready & sel),
    .char_data(u_data), .char_index(u_idx), .char_last(u_last), .done(u_done)
  );

  always_comb begin
    o_busy  = sel ? u_busy  : l_busy;
    o_valid = sel ? u_valid : l_valid;
    o_data  = sel ? u_data  : l_data;
    o_idx   = sel ? u_idx   : l_idx;
    o_last  = sel ? u_last  : l_last;
    o_done  = sel ? u_done  : l_done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},  32'(o_busy),  32'd0);
    chk({tag, ".valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".data"},  32'(o_data),  32'd0);
    chk({tag, ".index"}, 32'(o_idx),   32'd0);
    chk({tag, ".last"},  32'(o_last),  32'd0);
    chk({tag, ".done"},  32'(o_done),  32'd0);
  endtask

  // Receive a whole stream starting at the first offer cycle. alt selects
  // ready alternating 0,1,... ; poke_at pulses load (with new value) in SEND;
  // poke_done pulses load during the DONE cycle.
  task automatic take_stream(input string tag, input string exp, input bit alt,
                             input int poke_at, input bit poke_done);
    int len;
    int got;
    int cyc;
    len = exp.len();
    got = 0;
    cyc = 0;
    while (got < len && cyc < 200) begin
      char_ready = alt ? cyc[0] : 1'b1;
      if (cyc == poke_at) begin
        load  = 1'b1;
        value = 40'hFEEDFACE00;
      end else begin
        load  = 1'b0;
      end
      chk({tag, ".valid"}, 32'(o_valid), 32'd1);
      chk({tag, ".busy"},  32'(o_busy),  32'd1);
      chk({tag, ".data"},  32'(o_data),  32'(exp[got]));
      chk({tag, ".index"}, 32'(o_idx),   32'(len - 1 - got));
      chk({tag, ".last"},  32'(o_last),  32'(got == len - 1));
      chk({tag, ".done"},  32'(o_done),  32'd0);
      if (char_ready) got++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".count"}, 32'(got), 32'(len));
    char_ready = 1'b0;
    load = poke_done;
    value = 40'h1111111111;
    chk({tag, ".done_pulse"}, 32'(o_done),  32'd1);
    chk({tag, ".done_valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".done_busy"},  32'(o_busy),  32'd1);
    chk({tag, ".done_data"},  32'(o_data),  32'd0);
    @(negedge clk);
    load = 1'b0;
    chk_idle({tag, ".after"});
    @(negedge clk);
    chk_idle({tag, ".after2"});
  endtask

  initial begin
`ifdef DIGIT_STREAM_LZ_BLANK_EN
    s_plain = "      12af";
    s_zero  = "         0";
    s_seq   = " 123456789";
`else
    s_plain = "00000012af";
    s_zero  = "0000000000";
    s_seq   = "0123456789";
`endif
    s_upper = "FEDCBA9876";

    reset = 1'b1;
    load = 1'b0;
    char_ready = 1'b0;
    sel = 1'b0;
    value = 40'h0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset_l");
    sel = 1'b1;
    chk_idle("reset_u");
    sel = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk_idle("idle");

    // Plain stream, ready high
    value = 40'h00000012AF;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    take_stream("plain", s_plain, 1'b0, -1, 1'b0);

    // All-zero value
    value = 40'h0000000000;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    take_stream("zero", s_zero, 1'b0, -1, 1'b0);

    // Backpressure, ready alternating starting low
    value = 40'h0123456789;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    take_stream("bp", s_seq, 1'b1, -1, 1'b0);

    // Load pulses in SEND and in DONE are ignored
    value = 40'h0123456789;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    take_stream("ldbusy", s_seq, 1'b0, 3, 1'b1);

    // Reset mid-stream on the upper-case instance
    sel = 1'b1;
    value = 40'h0123456789;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    char_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("rst_pre.data",  32'(o_data), 32'(s_seq[k]));
      chk("rst_pre.index", 32'(o_idx),  32'(9 - k));
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    char_ready = 1'b0;
    chk_idle("rst_mid");
    @(negedge clk);
    chk_idle("rst_mid2");

    value = 40'hFEDCBA9876;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    take_stream("upper", s_upper, 1'b0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
